ram_arbiter: RTL



---
 rtl/ram_arbiter_if.sv | 33 +++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/response and RAM-side bus of the two-client RAM arbiter.
// Revision: 1.0
`default_nettype none

interface ram_arbiter_if #(
    parameter int N = 4,
    parameter int M = 8
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [1:0]     req_wr;
    logic [2*N-1:0] req_addr;
    logic [2*M-1:0] req_din;
    logic [1:0]     rsp_valid;
    logic [M-1:0]   rsp_dout;
    logic           init_done;
    logic           ram_wr;
    logic [N-1:0]   ram_addr;
    logic [M-1:0]   ram_din;
    logic [M-1:0]   ram_dout;

    modport slave (
        input  req_valid, req_wr, req_addr, req_din, ram_dout,
        output req_ready, rsp_valid, rsp_dout, init_done, ram_wr, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_wr, req_addr, req_din, ram_dout,
        input  req_ready, rsp_valid, rsp_dout, init_done, ram_wr, ram_addr, ram_din
    );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: clears a single-port RAM after reset, then round-robins two clients onto it.
// Revision: 1.0
`default_nettype none

module ram_arbiter #(
    parameter int N = 4,
    parameter int M = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [N:0] c_one = {{N{1'b0}}, 1'b1};

    state_t       r_state, w_state_nxt;
    logic [N:0]   r_cnt, w_cnt_nxt;
    logic         r_ram_wr, w_ram_wr_nxt;
    logic [N-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [M-1:0] r_ram_din, w_ram_din_nxt;
    logic [1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic         r_init_done, w_init_done_nxt;
    logic         r_last_grant, w_last_grant_nxt;
    logic         r_rd_pend, w_rd_pend_nxt;
    logic         r_rd_id, w_rd_id_nxt;
    logic [1:0]   w_ready;
    logic         w_sel;
    logic         w_sel_wr;
    logic [N-1:0] w_sel_addr;
    logic [M-1:0] w_sel_din;

    // Requester selected by the current grant; only meaningful when w_ready != 0
    assign w_sel      = w_ready[1];
    assign w_sel_wr   = w_sel ? bus.req_wr[1] : bus.req_wr[0];
    assign w_sel_addr = w_sel ? bus.req_addr[2*N-1:N] : bus.req_addr[N-1:0];
    assign w_sel_din  = w_sel ? bus.req_din[2*M-1:M] : bus.req_din[M-1:0];

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ram_wr_nxt     = 1'b0;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_din_nxt    = r_ram_din;
        w_init_done_nxt  = r_init_done;
        w_last_grant_nxt = r_last_grant;
        w_rd_pend_nxt    = 1'b0;
        w_rd_id_nxt      = r_rd_id;
        w_ready          = 2'b00;
        w_rsp_valid_nxt  = 2'b00;
        if (r_rd_pend) begin
            w_rsp_valid_nxt[r_rd_id] = 1'b1;
        end

        case (r_state)
            S_INIT: begin
                // Top bit of cnt marks that the last address has been presented
                if (r_cnt[N]) begin
                    w_state_nxt     = S_RUN;
                    w_init_done_nxt = 1'b1;
                end else begin
                    w_ram_wr_nxt   = 1'b1;
                    w_ram_addr_nxt = r_cnt[N-1:0];
                    w_ram_din_nxt  = '0;
                    w_cnt_nxt      = r_cnt + c_one;
                end
            end
            S_RUN: begin
                case (bus.req_valid)
                    2'b01:   w_ready = 2'b01;
                    2'b10:   w_ready = 2'b10;
                    2'b11:   w_ready = r_last_grant ? 2'b01 : 2'b10;
                    default: w_ready = 2'b00;
                endcase
                if (w_ready != 2'b00) begin
                    w_ram_wr_nxt     = w_sel_wr;
                    w_ram_addr_nxt   = w_sel_addr;
                    w_ram_din_nxt    = w_sel_wr ? w_sel_din : '0;
                    w_last_grant_nxt = w_sel;
                    w_rd_pend_nxt    = ~w_sel_wr;
                    w_rd_id_nxt      = w_sel;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_ram_wr     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_rsp_valid  <= 2'b00;
            r_init_done  <= 1'b0;
            r_last_grant <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_rd_id      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ram_wr     <= w_ram_wr_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_din    <= w_ram_din_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_init_done  <= w_init_done_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_rd_pend    <= w_rd_pend_nxt;
            r_rd_id      <= w_rd_id_nxt;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_dout  = bus.ram_dout;
    assign bus.init_done = r_init_done;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_din   = r_ram_din;
endmodule

`default_nettype wire
